// File: rtl/spi_fl_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_fl_cmd_ctrl
//  Description : CPU-facing command sequencer for the SPI flash master.
//                Holds TX data, flash address, command byte and command type.
//                A START issues a one-cycle valid strobe and tracks the
//                master's busy window. It captures the reply word when one
//                is expected, and reports busy/done/timeout/err status.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_fl_cmd_ctrl #(
    parameter int TO_W   = 16,
    parameter int TO_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst,              // asynchronous, active-low
    input  logic        valid,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] m_data_in,
    output logic [23:0] m_address,
    output logic [7:0]  m_command,
    output logic [2:0]  m_commtype,
    output logic        m_validflag,
    input  logic        m_tready,
    input  logic        m_validflag_out,
    input  logic [31:0] m_data_out
);

    localparam logic [TO_W-1:0] c_to_max = TO_W'(TO_CYC - 1);

    localparam logic [2:0] c_off_tx   = 3'd0;
    localparam logic [2:0] c_off_addr = 3'd1;
    localparam logic [2:0] c_off_cmd  = 3'd2;
    localparam logic [2:0] c_off_stat = 3'd3;
    localparam logic [2:0] c_off_rx   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_ACK   = 3'd2,
        S_RUN   = 3'd3,
        S_REPLY = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t            r_state;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_ready;
    logic [31:0]       r_rdata;
    logic [31:0]       r_txdata;
    logic [23:0]       r_addr;
    logic [7:0]        r_cmd;
    logic [2:0]        r_type;
    logic [31:0]       r_rxdata;
    logic              r_busy;
    logic              r_done;
    logic              r_timeout;
    logic              r_err;
    logic              r_vfo_q;
    logic              r_m_valid;
    logic [31:0]       r_m_data;
    logic [23:0]       r_m_addr;
    logic [7:0]        r_m_cmd;
    logic [2:0]        r_m_type;

    logic              w_acc;
    logic              w_wr;
    logic              w_rd;
    logic              w_wr_cfg;
    logic              w_drop;
    logic              w_wr_ok;
    logic              w_start;
    logic              w_w1c;
    logic              w_rise;
    logic              w_to_hit;
    logic [7:0]        w_cmd_new;
    logic [2:0]        w_type_new;
    logic [31:0]       w_rdata;

    // A request is taken on the first valid cycle while the ack is low.
    assign w_acc    = valid & ~r_ready;
    assign w_wr     = w_acc & (|wstrb);
    assign w_rd     = w_acc & ~(|wstrb);
    assign w_wr_cfg = w_wr & (addr <= c_off_cmd);
    // Configuration is frozen while a transaction is in flight.
    assign w_drop   = w_wr_cfg & r_busy;
    assign w_wr_ok  = w_wr_cfg & ~r_busy;
    assign w_start  = w_wr_ok & (addr == c_off_cmd) & wstrb[3] & wdata[31];
    assign w_w1c    = w_wr & (addr == c_off_stat) & wstrb[0];
    // Only a fresh low-to-high transition of the reply flag counts.
    assign w_rise   = m_validflag_out & ~r_vfo_q;
    assign w_to_hit = (r_to_cnt == c_to_max);

    // The START write itself may update the command fields; the master must see them.
    assign w_cmd_new  = wstrb[0] ? wdata[7:0]  : r_cmd;
    assign w_type_new = wstrb[1] ? wdata[10:8] : r_type;

    // Register read multiplexer; CMD bit 31 (START) always reads as zero.
    always_comb begin
        w_rdata = 32'h0;
        case (addr)
            c_off_tx:   w_rdata = r_txdata;
            c_off_addr: w_rdata = {8'h0, r_addr};
            c_off_cmd:  w_rdata = {21'h0, r_type, r_cmd};
            c_off_stat: w_rdata = {28'h0, r_err, r_timeout, r_done, r_busy};
            c_off_rx:   w_rdata = r_rxdata;
            default:    w_rdata = 32'h0;
        endcase
    end

    // Bus handshake: one-cycle ack with read data registered alongside it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready <= 1'b0;
            r_rdata <= 32'h0;
        end else begin
            r_ready <= w_acc;
            if (w_acc) begin
                r_rdata <= w_rd ? w_rdata : 32'h0;
            end
        end
    end

    // CPU-visible configuration registers with byte enables.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_txdata <= 32'h0;
            r_addr   <= 24'h0;
            r_cmd    <= 8'h0;
            r_type   <= 3'h0;
        end else if (w_wr_ok) begin
            case (addr)
                c_off_tx: begin
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb[b]) r_txdata[8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
                c_off_addr: begin
                    for (int b = 0; b < 3; b++) begin
                        if (wstrb[b]) r_addr[8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
                c_off_cmd: begin
                    r_cmd  <= w_cmd_new;
                    r_type <= w_type_new;
                end
                default: ;
            endcase
        end
    end

    // Command sequencer, timeout counter, status flags and master-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_to_cnt  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_err     <= 1'b0;
            r_rxdata  <= 32'h0;
            r_vfo_q   <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_data  <= 32'h0;
            r_m_addr  <= 24'h0;
            r_m_cmd   <= 8'h0;
            r_m_type  <= 3'b111;
        end else begin
            r_vfo_q <= m_validflag_out;

            // Write-one-to-clear first so that any same-cycle set below wins.
            if (w_w1c) begin
                if (wdata[1]) r_done    <= 1'b0;
                if (wdata[2]) r_timeout <= 1'b0;
                if (wdata[3]) r_err     <= 1'b0;
            end
            if (w_drop) r_err <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state   <= S_ISSUE;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_timeout <= 1'b0;
                        r_m_valid <= 1'b1;
                        r_m_data  <= r_txdata;
                        r_m_addr  <= r_addr;
                        r_m_cmd   <= w_cmd_new;
                        r_m_type  <= w_type_new;
                    end
                end
                S_ISSUE: begin
                    r_m_valid <= 1'b0;
                    r_state   <= S_ACK;
                    r_to_cnt  <= '0;
                end
                S_ACK: begin
                    if (!m_tready) begin
                        r_state  <= S_RUN;
                        r_to_cnt <= '0;
                    end else if (w_to_hit) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_RUN: begin
                    if (m_tready) begin
                        r_state  <= ((r_m_type == 3'b001) || (r_m_type == 3'b010)) ? S_REPLY : S_FIN;
                        r_to_cnt <= '0;
                    end else if (w_to_hit) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_REPLY: begin
                    if (w_rise) begin
                        r_rxdata <= m_data_out;
                        r_state  <= S_FIN;
                        r_to_cnt <= '0;
                    end else if (w_to_hit) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_m_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rdata       = r_rdata;
    assign ready       = r_ready;
    assign m_data_in   = r_m_data;
    assign m_address   = r_m_addr;
    assign m_command   = r_m_cmd;
    assign m_commtype  = r_m_type;
    assign m_validflag = r_m_valid;

endmodule
`default_nettype wire
